// File: rtl/packet_to_config_pkg.sv
// Shared framing constants, command codes and parser state encoding.
// Header/trailer values match the outbound sample-report packetiser.
// No logic here; pure definitions.
package packet_to_config_pkg;

  localparam logic [7:0] HDR = 8'h55;
  localparam logic [7:0] TRL = 8'haa;

  localparam logic [7:0] CMD_SET_SEL = 8'h01;
  localparam logic [7:0] CMD_CLR_OVR = 8'h02;
  localparam logic [7:0] CMD_DEBUG   = 8'h03;
  localparam logic [7:0] CMD_RESTART = 8'h04;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_DH,
    ST_DL,
    ST_CHK,
    ST_TAIL
  } state_t;

  function automatic logic chk_ok(input logic [7:0] cmd, input logic [7:0] dh,
                                  input logic [7:0] dl, input logic [7:0] chk);
    return chk == (cmd ^ dh ^ dl);
  endfunction

endpackage

// File: rtl/packet_to_config_rx_timeout_counter.sv
// Inter-byte idle counter; tc fires on the cycle the count sits at TIMEOUT_CYCLES-1.
// Latency: tc is combinational from the counter flop, one cycle wide.
// Backpressure: none; clear always takes priority over counting.
module packet_to_config_rx_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int TO_WIDTH       = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam logic [TO_WIDTH-1:0] TERM = TO_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [TO_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear)       cnt_d = '0;
    else if (enable) cnt_d = cnt_q + TO_WIDTH'(1);
  end

  assign tc = enable && !clear && (cnt_q == TERM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/packet_to_config.sv
// Frames 55|cmd|dH|dL|chk|aa packets from the UART and executes config commands.
// Latency: outputs and pulses appear the cycle after the trailer byte is sampled.
// Backpressure: none; every rx_valid strobe is consumed, down to one per cycle.
module packet_to_config
  import packet_to_config_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int TO_WIDTH       = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  output logic [11:0] ROSelOvr,
  output logic        ovrEn,
  output logic        debugMode,
  output logic        restartSearch,
  output logic        cmdValid,
  output logic        frameError
);

  state_t      state_q, state_d;
  logic [7:0]  cmd_q, cmd_d, dh_q, dh_d, dl_q, dl_d, chk_q, chk_d;
  logic [11:0] sel_q, sel_d;
  logic        ovr_q, ovr_d, dbg_q, dbg_d;
  logic        restart_q, restart_d, valid_q, valid_d, ferr_q, ferr_d;
  logic        to_tc;

  packet_to_config_rx_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TO_WIDTH      (TO_WIDTH)
  ) u_timeout (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (rx_valid || (state_q == ST_IDLE)),
    .enable(state_q != ST_IDLE),
    .tc    (to_tc)
  );

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    dh_d      = dh_q;
    dl_d      = dl_q;
    chk_d     = chk_q;
    sel_d     = sel_q;
    ovr_d     = ovr_q;
    dbg_d     = dbg_q;
    restart_d = 1'b0;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
    // A byte on the terminal-count cycle wins over the timeout.
    if (rx_valid) begin
      case (state_q)
        ST_IDLE: if (rx_byte == HDR) state_d = ST_CMD;
        ST_CMD:  begin cmd_d = rx_byte; state_d = ST_DH;   end
        ST_DH:   begin dh_d  = rx_byte; state_d = ST_DL;   end
        ST_DL:   begin dl_d  = rx_byte; state_d = ST_CHK;  end
        ST_CHK:  begin chk_d = rx_byte; state_d = ST_TAIL; end
        ST_TAIL: begin
          state_d = ST_IDLE;
          if (rx_byte == TRL && chk_ok(cmd_q, dh_q, dl_q, chk_q)) begin
            case (cmd_q)
              CMD_SET_SEL: begin sel_d = {dh_q[3:0], dl_q}; ovr_d = 1'b1; valid_d = 1'b1; end
              CMD_CLR_OVR: begin ovr_d = 1'b0; valid_d = 1'b1; end
              CMD_DEBUG:   begin dbg_d = dl_q[0]; valid_d = 1'b1; end
              CMD_RESTART: begin restart_d = 1'b1; valid_d = 1'b1; end
              default:     ferr_d = 1'b1;
            endcase
          end else begin
            ferr_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (to_tc) begin
      state_d = ST_IDLE;
      ferr_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cmd_q     <= '0;
      dh_q      <= '0;
      dl_q      <= '0;
      chk_q     <= '0;
      sel_q     <= '0;
      ovr_q     <= 1'b0;
      dbg_q     <= 1'b0;
      restart_q <= 1'b0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      dh_q      <= dh_d;
      dl_q      <= dl_d;
      chk_q     <= chk_d;
      sel_q     <= sel_d;
      ovr_q     <= ovr_d;
      dbg_q     <= dbg_d;
      restart_q <= restart_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
    end
  end

  assign ROSelOvr      = sel_q;
  assign ovrEn         = ovr_q;
  assign debugMode     = dbg_q;
  assign restartSearch = restart_q;
  assign cmdValid      = valid_q;
  assign frameError    = ferr_q;

endmodule

// File: tb/tb_packet_to_config.sv
// Randomized and directed bench: a packet-level model predicts pulse events into a queue;
// a negedge monitor pops and compares whenever any pulse output is high.
module tb_packet_to_config;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        rx_valid = 1'b0;
  logic [11:0] ROSelOvr;
  logic        ovrEn, debugMode, restartSearch, cmdValid, frameError;

  packet_to_config #(.TIMEOUT_CYCLES(TO), .TO_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .ROSelOvr(ROSelOvr), .ovrEn(ovrEn), .debugMode(debugMode),
    .restartSearch(restartSearch), .cmdValid(cmdValid), .frameError(frameError)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          stamp;
    logic        cv, fe, rs;
    logic [11:0] sel;
    logic        ovr, dbg;
  } ev_t;

  ev_t         exp_q[$];
  logic [7:0]  m_pkt[$];
  int          m_idle = 0;
  logic [11:0] m_sel = '0;
  logic        m_ovr = 1'b0, m_dbg = 1'b0;
  int          total = 0, bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic void model_reset();
    m_pkt.delete();
    m_idle = 0;
    m_sel  = '0;
    m_ovr  = 1'b0;
    m_dbg  = 1'b0;
  endfunction

  // Packet-level reference: collect bytes after a header, judge the 6-byte frame as a whole.
  function automatic void model_step(input bit v, input logic [7:0] b, input int stamp);
    ev_t e;
    bit fire = 0;
    logic [7:0] c, dh, dl, ck, tr;
    e.cv = 0; e.fe = 0; e.rs = 0;
    if (v) begin
      m_idle = 0;
      if (m_pkt.size() == 0) begin
        if (b == 8'h55) m_pkt.push_back(b);
      end else begin
        m_pkt.push_back(b);
        if (m_pkt.size() == 6) begin
          c = m_pkt[1]; dh = m_pkt[2]; dl = m_pkt[3]; ck = m_pkt[4]; tr = m_pkt[5];
          if (tr != 8'haa || ck != (c ^ dh ^ dl)) e.fe = 1;
          else if (c == 8'h01) begin m_sel = {dh[3:0], dl}; m_ovr = 1; e.cv = 1; end
          else if (c == 8'h02) begin m_ovr = 0; e.cv = 1; end
          else if (c == 8'h03) begin m_dbg = dl[0]; e.cv = 1; end
          else if (c == 8'h04) begin e.rs = 1; e.cv = 1; end
          else e.fe = 1;
          fire = 1;
          m_pkt.delete();
        end
      end
    end else if (m_pkt.size() != 0) begin
      m_idle++;
      if (m_idle == TO) begin
        e.fe = 1;
        fire = 1;
        m_pkt.delete();
        m_idle = 0;
      end
    end
    if (fire) begin
      e.stamp = stamp; e.sel = m_sel; e.ovr = m_ovr; e.dbg = m_dbg;
      exp_q.push_back(e);
    end
  endfunction

  task automatic drive(input bit v, input logic [7:0] b);
    @(posedge clk);
    #1;
    rx_valid = v;
    rx_byte  = v ? b : 8'($urandom);
    model_step(v, b, cyc + 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 8'h00);
  endtask

  task automatic send6(input logic [7:0] c, dh, dl, ck, tr);
    drive(1, 8'h55); drive(1, c); drive(1, dh); drive(1, dl); drive(1, ck); drive(1, tr);
  endtask

  always @(negedge clk) begin
    if (rst_n && (cmdValid || frameError || restartSearch)) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pulse: got cv=%b fe=%b rs=%b want no pulse (cycle %0d)",
                 cmdValid, frameError, restartSearch, cyc);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        check("event_cycle", 32'(cyc), 32'(e.stamp));
        check("event_outputs",
              {15'd0, cmdValid, frameError, restartSearch, ROSelOvr, ovrEn, debugMode},
              {15'd0, e.cv, e.fe, e.rs, e.sel, e.ovr, e.dbg});
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got no end of test want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] c, dh, dl, ck, tr, bytes[6];
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state", {14'd0, ROSelOvr, ovrEn, debugMode, restartSearch, cmdValid, frameError}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    send6(8'h01, 8'h0A, 8'hBC, 8'hB7, 8'hAA);
    idle(3);
    check("sel_after_set", {19'd0, ROSelOvr, ovrEn}, {19'd0, 12'hABC, 1'b1});
    send6(8'h03, 8'h00, 8'h01, 8'h02, 8'hAA);
    send6(8'h04, 8'h00, 8'h00, 8'h04, 8'hAA);
    drive(1, 8'h12); drive(1, 8'h34);
    send6(8'h02, 8'h00, 8'h00, 8'h02, 8'hAA);
    send6(8'h01, 8'h0A, 8'hBC, 8'h00, 8'hAA);
    send6(8'h01, 8'h0A, 8'hBC, 8'hB7, 8'hAB);
    send6(8'h7F, 8'h00, 8'h00, 8'h7F, 8'hAA);
    // Trailer slot holding a header must not start a new frame.
    send6(8'h01, 8'h05, 8'h06, 8'h02, 8'h55);
    send6(8'h03, 8'h00, 8'h00, 8'h03, 8'hAA);
    idle(2);
    check("regs_after_rejects", {17'd0, ROSelOvr, ovrEn, debugMode}, {17'd0, 12'hABC, 1'b0, 1'b0});

    drive(1, 8'h55); drive(1, 8'h01); idle(TO);
    send6(8'h01, 8'h03, 8'h21, 8'h23, 8'hAA);
    drive(1, 8'h55); drive(1, 8'h01); idle(TO - 1);
    drive(1, 8'h0A); drive(1, 8'hBC); drive(1, 8'hB7); drive(1, 8'hAA);
    idle(2);

    drive(1, 8'h55); drive(1, 8'h01); drive(1, 8'h0A);
    @(posedge clk); #1;
    rst_n = 1'b0; rx_valid = 1'b0;
    model_reset();
    @(posedge clk); @(negedge clk);
    check("midpacket_reset", {14'd0, ROSelOvr, ovrEn, debugMode, restartSearch, cmdValid, frameError}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    send6(8'h01, 8'h0F, 8'hED, 8'hE3, 8'hAA);
    idle(2);

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        drive(1, 8'($urandom));
      end else begin
        c  = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(1, 4));
        dh = 8'($urandom);
        dl = 8'($urandom);
        ck = c ^ dh ^ dl;
        tr = 8'haa;
        if ($urandom_range(0, 9) == 0) ck = ck ^ 8'($urandom_range(1, 255));
        if ($urandom_range(0, 9) == 0) tr = 8'($urandom);
        bytes[0] = 8'h55; bytes[1] = c; bytes[2] = dh; bytes[3] = dl; bytes[4] = ck; bytes[5] = tr;
        for (int k = 0; k < 6; k++) begin
          drive(1, bytes[k]);
          if ($urandom_range(0, 19) == 0) idle($urandom_range(TO - 1, TO + 1));
          else idle($urandom_range(0, 1) * $urandom_range(0, 2));
        end
      end
    end

    idle(TO + 4);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("final_regs", {18'd0, ROSelOvr, ovrEn, debugMode}, {18'd0, m_sel, m_ovr, m_dbg});
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
